// File: rtl/sparc_ifu_thrsched.sv
// Fetch thread picker: chooses which of four hardware threads owns fetch,
// rotating fairly between ready threads and enforcing a run quantum.
module sparc_ifu_thrsched #(
  parameter int SW_QUANTUM = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] thr0_state,
  input  logic [4:0] thr1_state,
  input  logic [4:0] thr2_state,
  input  logic [4:0] thr3_state,
  input  logic       switch_req,
  input  logic       stall_f,
  input  logic       spec_en,
  output logic [3:0] schedule,
  output logic       switch_out,
  output logic [3:0] thr_f,
  output logic       thr_valid,
  output logic       thr_f_spec,
  output logic       no_rdy
);

  localparam logic [4:0] ST_RDY      = 5'b11001;
  localparam logic [4:0] ST_RUN      = 5'b00101;
  localparam logic [4:0] ST_SPEC_RDY = 5'b10011;
  localparam logic [4:0] ST_SPEC_RUN = 5'b00111;
  localparam logic [5:0] CNT_MAX     = 6'(SW_QUANTUM - 1);

  typedef enum logic [1:0] {
    P_IDLE   = 2'd0,
    P_RUN    = 2'd1,
    P_SWITCH = 2'd2
  } pick_state_e;

  pick_state_e state_q, state_d;
  logic [3:0]  thr_f_q, thr_f_d;
  logic        thr_valid_q, thr_valid_d;
  logic        thr_f_spec_q, thr_f_spec_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [1:0]  last_thr_q, last_thr_d;

  logic [4:0] thr_state [4];
  logic [3:0] is_rdy, is_spec_rdy, is_running, is_run;

  assign thr_state[0] = thr0_state;
  assign thr_state[1] = thr1_state;
  assign thr_state[2] = thr2_state;
  assign thr_state[3] = thr3_state;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_dec
      assign is_rdy[gi]      = (thr_state[gi] == ST_RDY);
      assign is_spec_rdy[gi] = spec_en && (thr_state[gi] == ST_SPEC_RDY);
      assign is_run[gi]      = (thr_state[gi] == ST_RUN);
      assign is_running[gi]  = is_run[gi] || (thr_state[gi] == ST_SPEC_RUN);
    end
  endgenerate

  // Round-robin scan starting after last_thr; offset 4 lands on last_thr itself,
  // so it is only chosen when nothing else in its class is eligible.
  logic [1:0] scan_idx, rdy_idx, spec_idx, pick_idx;
  logic       rdy_found, spec_found;

  always_comb begin
    scan_idx   = '0;
    rdy_idx    = '0;
    spec_idx   = '0;
    rdy_found  = 1'b0;
    spec_found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      scan_idx = last_thr_q + 2'(k);
      if (!rdy_found && is_rdy[scan_idx]) begin
        rdy_idx   = scan_idx;
        rdy_found = 1'b1;
      end
      if (!spec_found && is_spec_rdy[scan_idx]) begin
        spec_idx   = scan_idx;
        spec_found = 1'b1;
      end
    end
  end

  logic any_elig, owner_running, owner_ldhit, do_pick, do_switch;

  assign any_elig      = rdy_found || spec_found;
  assign pick_idx      = rdy_found ? rdy_idx : spec_idx;
  assign owner_running = |(thr_f_q & is_running);
  assign owner_ldhit   = |(thr_f_q & is_run);
  assign do_pick       = (state_q == P_IDLE) && !stall_f && any_elig;
  assign do_switch     = (state_q == P_RUN) && owner_running && !stall_f &&
                         (switch_req || ((cnt_q == CNT_MAX) && any_elig));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= P_IDLE;
      thr_f_q      <= 4'b0001;
      thr_valid_q  <= 1'b0;
      thr_f_spec_q <= 1'b0;
      cnt_q        <= '0;
      last_thr_q   <= 2'd3;
    end else begin
      state_q      <= state_d;
      thr_f_q      <= thr_f_d;
      thr_valid_q  <= thr_valid_d;
      thr_f_spec_q <= thr_f_spec_d;
      cnt_q        <= cnt_d;
      last_thr_q   <= last_thr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    thr_f_d      = thr_f_q;
    thr_valid_d  = thr_valid_q;
    thr_f_spec_d = thr_f_spec_q;
    cnt_d        = cnt_q;
    last_thr_d   = last_thr_q;
    case (state_q)
      P_IDLE: begin
        if (do_pick) begin
          state_d      = P_RUN;
          thr_f_d      = 4'b0001 << pick_idx;
          last_thr_d   = pick_idx;
          thr_valid_d  = 1'b1;
          thr_f_spec_d = !rdy_found;
          cnt_d        = '0;
        end
      end
      P_RUN: begin
        // Owner leaving on its own takes precedence over any requested switch.
        if (!owner_running) begin
          state_d     = P_IDLE;
          thr_valid_d = 1'b0;
        end else if (do_switch) begin
          state_d     = P_SWITCH;
          thr_valid_d = 1'b0;
        end else begin
          if (!stall_f && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 6'd1;
          end
          if (owner_ldhit) begin
            thr_f_spec_d = 1'b0;
          end
        end
      end
      P_SWITCH: begin
        state_d     = P_IDLE;
        thr_valid_d = 1'b0;
      end
      default: begin
        state_d     = P_IDLE;
        thr_valid_d = 1'b0;
      end
    endcase
  end

  // Pulses are masked by reset so they drop immediately on an asynchronous reset.
  always_comb begin
    schedule   = '0;
    switch_out = 1'b0;
    if (!reset) begin
      if (do_pick) begin
        schedule = 4'b0001 << pick_idx;
      end
      switch_out = do_switch;
    end
  end

  assign thr_f      = thr_f_q;
  assign thr_valid  = thr_valid_q;
  assign thr_f_spec = thr_f_spec_q;
  assign no_rdy     = !any_elig;

endmodule
